// File: rtl/fpga_rst_seq_pkg.sv
// fpga_rst_seq_pkg: shared state encodings, reset-cause codes and
// output-decode helpers for the fpga_rst_seq reset sequencer.
package fpga_rst_seq_pkg;

   // Sequencer states (3-bit encoding; 6 and 7 are unused).
   typedef enum logic [2:0] {
      ST_RESET     = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_POR_HOLD  = 3'd2,
      ST_SYS_HOLD  = 3'd3,
      ST_RUN       = 3'd4,
      ST_SWRST     = 3'd5
   } state_t;

   // Cause of the last reset as reported on reset_cause.
   localparam logic [1:0] CAUSE_POR    = 2'd0;
   localparam logic [1:0] CAUSE_LOCK   = 2'd1;
   localparam logic [1:0] CAUSE_SW     = 2'd2;
   localparam logic [1:0] CAUSE_LOCKUP = 2'd3;

   // The power-on reset is released once the sequence reaches SYS_HOLD.
   function automatic logic po_released(input state_t s);
      return (s == ST_SYS_HOLD) || (s == ST_RUN) || (s == ST_SWRST);
   endfunction

   // The system reset (and reset_done) are released only in RUN.
   function automatic logic sys_released(input state_t s);
      return (s == ST_RUN);
   endfunction

endpackage

// File: rtl/fpga_rst_seq_sync_2ff.sv
// fpga_sync_2ff: single-bit two-flop synchroniser, async active-high
// reset to 0. Used for every input that is asynchronous to clk_in.
module fpga_sync_2ff (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Two-stage capture of the asynchronous input into the i_clk domain.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/fpga_rst_seq.sv
// fpga_rst_seq: ordered PORESETn / HRESETn sequencer for a Cortex-M0
// subsystem, clocked by the PLL output. Handles lock qualification, lock
// loss, software reset requests and reports the last reset cause.
// Optional feature: define FPGA_RST_SEQ_LOCKUP_RESET_EN to let core LOCKUP
// trigger (and prolong) a software-style reset with cause 3.
module fpga_rst_seq
   import fpga_rst_seq_pkg::*;
#(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int POR_HOLD_CYCLES    = 256,
   parameter int SYS_HOLD_CYCLES    = 64
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       pll_locked,
   input  logic       sys_reset_req,
   input  logic       lockup,
   output logic       po_reset_n,
   output logic       h_reset_n,
   output logic       reset_done,
   output logic [1:0] reset_cause
);

   // One shared down-counter sized for the longest phase, plus one bit.
   localparam int MAX_A  = (LOCK_STABLE_CYCLES > POR_HOLD_CYCLES) ?
                           LOCK_STABLE_CYCLES : POR_HOLD_CYCLES;
   localparam int MAX_C  = (MAX_A > SYS_HOLD_CYCLES) ? MAX_A : SYS_HOLD_CYCLES;
   localparam int CNT_W  = $clog2(MAX_C) + 1;

   // Reload values: a phase of N cycles counts N-1 down to 0 and leaves
   // on the edge that finds the counter at 0.
   localparam logic [CNT_W-1:0] LD_LOCK  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_POR   = CNT_W'(POR_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_SYS   = CNT_W'(SYS_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             w_lk_s;
   logic             w_rq_s;
   logic             w_lu_s;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_dec;
   logic [1:0]       r_cause;
   logic [1:0]       w_cause_nxt;
   logic             w_lock_lost;
   logic             r_po_reset_n;
   logic             r_h_reset_n;
   logic             r_reset_done;

   fpga_sync_2ff u_sync_lock (
      .i_clk (clk_in),
      .i_rst (reset),
      .i_d   (pll_locked),
      .o_q   (w_lk_s)
   );

   fpga_sync_2ff u_sync_req (
      .i_clk (clk_in),
      .i_rst (reset),
      .i_d   (sys_reset_req),
      .o_q   (w_rq_s)
   );

`ifdef FPGA_RST_SEQ_LOCKUP_RESET_EN
   fpga_sync_2ff u_sync_lockup (
      .i_clk (clk_in),
      .i_rst (reset),
      .i_d   (lockup),
      .o_q   (w_lu_s)
   );
`else
   // LOCKUP is ignored in this build; the port is kept for pin compatibility.
   logic w_unused_lockup;
   assign w_unused_lockup = lockup;
   assign w_lu_s          = 1'b0;
`endif

   assign w_cnt_dec   = r_cnt - CNT_ONE;

   // Losing lock anywhere past WAIT_LOCK overrides every other transition.
   assign w_lock_lost = ~w_lk_s & ((r_state == ST_POR_HOLD) ||
                                   (r_state == ST_SYS_HOLD) ||
                                   (r_state == ST_RUN)      ||
                                   (r_state == ST_SWRST));

   // Next-state, counter reload/decrement and reset-cause selection.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cause_nxt = r_cause;
      if (w_lock_lost) begin
         w_state_nxt = ST_WAIT_LOCK;
         w_cnt_nxt   = LD_LOCK;
         w_cause_nxt = CAUSE_LOCK;
      end else begin
         case (r_state)
            ST_RESET: begin
               w_state_nxt = ST_WAIT_LOCK;
               w_cnt_nxt   = LD_LOCK;
            end
            ST_WAIT_LOCK: begin
               if (!w_lk_s) begin
                  w_cnt_nxt = LD_LOCK;
               end else if (r_cnt == CNT_ZERO) begin
                  w_state_nxt = ST_POR_HOLD;
                  w_cnt_nxt   = LD_POR;
               end else begin
                  w_cnt_nxt = w_cnt_dec;
               end
            end
            ST_POR_HOLD: begin
               if (r_cnt == CNT_ZERO) begin
                  w_state_nxt = ST_SYS_HOLD;
                  w_cnt_nxt   = LD_SYS;
               end else begin
                  w_cnt_nxt = w_cnt_dec;
               end
            end
            ST_SYS_HOLD: begin
               if (r_cnt == CNT_ZERO) begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = CNT_ZERO;
               end else begin
                  w_cnt_nxt = w_cnt_dec;
               end
            end
            ST_RUN: begin
               // Lockup takes precedence when both requests arrive together.
               if (w_lu_s) begin
                  w_state_nxt = ST_SWRST;
                  w_cnt_nxt   = LD_SYS;
                  w_cause_nxt = CAUSE_LOCKUP;
               end else if (w_rq_s) begin
                  w_state_nxt = ST_SWRST;
                  w_cnt_nxt   = LD_SYS;
                  w_cause_nxt = CAUSE_SW;
               end else begin
                  w_cnt_nxt = CNT_ZERO;
               end
            end
            ST_SWRST: begin
               // Minimum hold, then wait (counter parked at 0) for release.
               if (r_cnt != CNT_ZERO) begin
                  w_cnt_nxt = w_cnt_dec;
               end else if (w_rq_s || w_lu_s) begin
                  w_cnt_nxt = CNT_ZERO;
               end else begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = CNT_ZERO;
               end
            end
            default: begin
               w_state_nxt = ST_RESET;
               w_cnt_nxt   = CNT_ZERO;
            end
         endcase
      end
   end

   // State, counter, cause and outputs; outputs decode the next state so
   // they switch on the same edge as the state register.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_state      <= ST_RESET;
         r_cnt        <= CNT_ZERO;
         r_cause      <= CAUSE_POR;
         r_po_reset_n <= 1'b0;
         r_h_reset_n  <= 1'b0;
         r_reset_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_cause      <= w_cause_nxt;
         r_po_reset_n <= po_released(w_state_nxt);
         r_h_reset_n  <= sys_released(w_state_nxt);
         r_reset_done <= sys_released(w_state_nxt);
      end
   end

   assign po_reset_n  = r_po_reset_n;
   assign h_reset_n   = r_h_reset_n;
   assign reset_done  = r_reset_done;
   assign reset_cause = r_cause;

endmodule
